cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run controller that sequences the HLS RV32I core and owns its 1K x 32 single-port SRAM when the core is not running. It preloads the SRAM from a host word stream and starts the core with the ap_start/ap_ready/ap_idle handshake. It waits for completion under an optional watchdog, then gives the host single-word readback of results. A 2:1 port mux sits between the core memory port and the SRAM.

Parameters:
AW, 10, SRAM word-address width (depth 2**AW).
DW, 32, data width.
WDOG_CYCLES, 1000000, max RUN cycles before abort (only with RUN_WDOG_EN).

Ports:
ap_clk  in  1  system clock
ap_rst_n  in  1  asynchronous active-low reset
cmd_load  in  1  pulse: begin program load at address 0
cmd_run  in  1  pulse: start core
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted when valid&ready
ld_data  in  DW  load word
ld_last  in  1  final load word
rd_req  in  1  pulse: read one SRAM word
rd_addr  in  AW  readback address
rd_valid  out  1  one-cycle readback strobe
rd_data  out  DW  readback data, held until next rd_valid
busy  out  1  state not in {IDLE, DONE}
done  out  1  high in DONE
timeout  out  1  sticky, set on watchdog abort, cleared by cmd_load/cmd_run
cpu_rst  out  1  active-high core reset
cpu_start  out  1  core ap_start
cpu_ready  in  1  core ap_ready
cpu_idle  in  1  core ap_idle
cpu_addr  in  AW  core memory address
cpu_we  in  1  core write enable
cpu_d  in  DW  core write data
cpu_strb  in  4  core byte strobes
cpu_q  out  DW  core read data
sram_addr  out  AW  SRAM address
sram_we  out  4  SRAM byte write enables
sram_din  out  DW  SRAM write data
sram_dout  in  DW  SRAM read data, one-cycle latency

Behaviour:
- Reset (async assert, sync deassert): state IDLE. ld_ready=0, rd_valid=0, rd_data=0, done=0, timeout=0, cpu_start=0, sram_we=0. cpu_rst=1 while ap_rst_n low and for 2 cycles after release.
- States: IDLE, LOAD, START, RUN, DONE, READ, ABORT.
- Commands are accepted only in IDLE or DONE. Priority is cmd_load > cmd_run > rd_req. Commands in any other state are ignored.
- LOAD: address counter cleared to 0 on entry. ld_ready=1. Each accepted word writes sram_we=4'hF to the counter address, then the counter increments.
  - Load ends (next cycle IDLE, ld_ready=0) on an accepted ld_last, or after writing address 2**AW-1. No wrap; excess words are not accepted.
- START: cpu_start=1 held until cpu_ready sampled high, then RUN with cpu_start=0 the next cycle.
- RUN: SRAM mux selects core: sram_addr=cpu_addr, sram_we={4{cpu_we}}&cpu_strb, sram_din=cpu_d, cpu_q=sram_dout.
  - The first cycle after START is ignored for idle detection.
  - cpu_idle=1 sampled thereafter moves to DONE.
- Outside RUN: the controller drives the SRAM. cpu_q is still wired to sram_dout. cpu_we is ignored.
- READ: rd_addr registered on acceptance and driven on sram_addr. sram_dout is captured 2 cycles after rd_req. rd_valid pulses that cycle. Returns to the originating state (IDLE or DONE).
- ABORT: cpu_rst=1 for 2 cycles, then DONE with timeout=1.
- done is deasserted on leaving DONE via any accepted command.
- ap_rst_n assertion mid-LOAD/RUN: immediate IDLE. SRAM contents undefined for the partial load.

Optional Feature:
RUN_WDOG_EN: when defined, a cycle counter (width clog2(WDOG_CYCLES+1)) clears on RUN entry and increments each RUN cycle. Reaching WDOG_CYCLES without cpu_idle enters ABORT. When undefined, RUN waits indefinitely, ABORT is unreachable, timeout is tied 0, and no counter is synthesized.

Test Plan:
- Load 4 words 0x00000013, 0x00100093, 0x00208113, 0x0000006F (ld_last on 4th) -> SRAM[0..3] hold the words; ld_ready drops the cycle after; busy=0.
- cmd_run with core model asserting cpu_ready 3 cycles after cpu_start and cpu_idle 50 cycles later -> cpu_start high exactly 4 cycles, done=1 one cycle after idle sampled, core writes reach SRAM with strobe masking (strb 4'b0010 changes byte 1 only).
- In DONE, rd_req with rd_addr=0x3FF after core wrote 0xDEADBEEF there -> rd_valid 2 cycles later, rd_data=0xDEADBEEF.
- Load stream of 1025 words without ld_last -> 1024 writes, last at 0x3FF, word 1025 not accepted (ld_ready=0).
- RUN_WDOG_EN, WDOG_CYCLES=100, core never idles -> cpu_rst high 2 cycles at RUN cycle 100, done=1, timeout=1; next cmd_run clears timeout.
- Simultaneous cmd_load+cmd_run+rd_req in IDLE -> LOAD entered only; ap_rst_n pulsed low mid-RUN -> IDLE, cpu_rst=1 until 2 cycles after release.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller for the HLS RV32I core: SRAM preload, ap_start/ap_ready/ap_idle sequencing,
// single-word readback and the core/controller SRAM port mux. Define RUN_WDOG_EN for the RUN watchdog.
module cpu_run_ctrl #(
    parameter int AW          = 10,
    parameter int DW          = 32,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          cmd_load,
    input  logic          cmd_run,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          cpu_rst,
    output logic          cpu_start,
    input  logic          cpu_ready,
    input  logic          cpu_idle,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_d,
    input  logic [3:0]    cpu_strb,
    output logic [DW-1:0] cpu_q,
    output logic [AW-1:0] sram_addr,
    output logic [3:0]    sram_we,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic [2:0]    dbg_state
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_ABORT = 3'd6;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ret_done_q, ret_done_d;
    logic          phase_q, phase_d;
    logic [1:0]    rst_cnt_q;
    logic          cmd_ok;
    logic          ld_fire;
    logic          wdog_hit;

    // Load handshake: a word transfers on a cycle where ld_valid and ld_ready are both high;
    // ld_ready is high for exactly the cycles spent in LOAD.
    assign cmd_ok  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign ld_fire = (state_q == S_LOAD) && ld_valid;

`ifdef RUN_WDOG_EN
    localparam int WCW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_CYCLES - 1);

    logic [WCW-1:0] wdog_q;
    logic           timeout_q;

    assign wdog_hit = (state_q == S_RUN) && (wdog_q == WDOG_LAST) && !(phase_q && cpu_idle);
    assign timeout  = timeout_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q <= (state_q == S_RUN) ? wdog_q + 1'b1 : '0;
            if (cmd_ok && (cmd_load || cmd_run)) begin
                timeout_q <= 1'b0;
            end else if (wdog_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ret_done_d = ret_done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cmd_load) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else if (cmd_run) begin
                    state_d = S_START;
                end else if (rd_req) begin
                    state_d    = S_READ;
                    rd_addr_d  = rd_addr;
                    ret_done_d = (state_q == S_DONE);
                end
            end
            S_LOAD: begin
                if (ld_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (ld_last || (cnt_q == LAST_ADDR)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_START: begin
                if (cpu_ready) begin
                    state_d = S_RUN;
                end
            end
            // phase_q is low on the first RUN cycle, when ap_idle may still be stale.
            S_RUN: begin
                if (phase_q && cpu_idle) begin
                    state_d = S_DONE;
                end else if (wdog_hit) begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                if (phase_q) begin
                    state_d = S_DONE;
                end
            end
            S_READ: begin
                if (phase_q) begin
                    rd_data_d  = sram_dout;
                    rd_valid_d = 1'b1;
                    state_d    = ret_done_q ? S_DONE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        phase_d = (state_d == state_q);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ret_done_q <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ret_done_q <= ret_done_d;
            phase_q    <= phase_d;
        end
    end

    // Core reset stretch: loaded while ap_rst_n is low, then counts down two cycles.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_cnt_q <= 2'd2;
        end else if (rst_cnt_q != 2'd0) begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
        end
    end

    always_comb begin
        if (state_q == S_RUN) begin
            sram_addr = cpu_addr;
            sram_we   = {4{cpu_we}} & cpu_strb;
            sram_din  = cpu_d;
        end else begin
            sram_addr = (state_q == S_READ) ? rd_addr_q : cnt_q;
            sram_we   = ld_fire ? 4'hF : 4'h0;
            sram_din  = ld_data;
        end
    end

    assign ld_ready  = (state_q == S_LOAD);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy      = !cmd_ok;
    assign done      = (state_q == S_DONE);
    assign cpu_rst   = (rst_cnt_q != 2'd0) || (state_q == S_ABORT);
    assign cpu_start = (state_q == S_START);
    assign cpu_q     = sram_dout;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: scripted load/run/read phases with random data and command noise,
// per-cycle output expectations, and a word-level SRAM image model.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int WDOG  = 100;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          cmd_load, cmd_run, ld_valid, ld_last, rd_req;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] rd_addr;
    logic          cpu_ready, cpu_idle, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_d;
    logic [3:0]    cpu_strb;
    logic [DW-1:0] sram_dout;
    logic          ld_ready, rd_valid, busy, done, timeout, cpu_rst, cpu_start;
    logic [DW-1:0] rd_data, cpu_q, sram_din;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_we;
    logic [2:0]    dbg_state;

    logic [DW-1:0] mem [0:DEPTH-1] = '{default: '0};
    logic [DW-1:0] model_mem [0:DEPTH-1];
    logic [DW-1:0] prog [0:3];

    bit            chk_en = 1'b0;
    bit            e_busy, e_done, e_ld_ready, e_start, e_rst, e_tmo, e_rvalid, e_mux;
    logic [3:0]    e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdata;
    int            n_checks = 0;
    int            n_pass = 0;

    cpu_run_ctrl #(.AW(AW), .DW(DW), .WDOG_CYCLES(WDOG)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_load(cmd_load), .cmd_run(cmd_run),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .timeout(timeout), .cpu_rst(cpu_rst), .cpu_start(cpu_start),
        .cpu_ready(cpu_ready), .cpu_idle(cpu_idle), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_d(cpu_d), .cpu_strb(cpu_strb), .cpu_q(cpu_q), .sram_addr(sram_addr),
        .sram_we(sram_we), .sram_din(sram_din), .sram_dout(sram_dout), .dbg_state(dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    // Byte-write SRAM with one-cycle read latency.
    always @(posedge ap_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        end
        sram_dout <= mem[sram_addr];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endfunction

    always @(negedge ap_clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("ld_ready", 32'(ld_ready), 32'(e_ld_ready));
            chk("cpu_start", 32'(cpu_start), 32'(e_start));
            chk("cpu_rst", 32'(cpu_rst), 32'(e_rst));
            chk("timeout", 32'(timeout), 32'(e_tmo));
            chk("rd_valid", 32'(rd_valid), 32'(e_rvalid));
            chk("rd_data", rd_data, e_rdata);
            chk("cpu_q", cpu_q, sram_dout);
            if (e_mux) begin
                chk("mux_addr", 32'(sram_addr), 32'(cpu_addr));
                chk("mux_we", 32'(sram_we), 32'({4{cpu_we}} & cpu_strb));
                chk("mux_din", sram_din, cpu_d);
            end else begin
                chk("sram_we", 32'(sram_we), 32'(e_we));
                if (e_we != 4'h0) begin
                    chk("ld_addr", 32'(sram_addr), 32'(e_addr));
                    chk("ld_din", sram_din, ld_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic noise();
        cmd_load = ($urandom_range(0, 7) == 0);
        cmd_run  = ($urandom_range(0, 7) == 0);
        rd_req   = ($urandom_range(0, 7) == 0);
        rd_addr  = 10'($urandom_range(0, DEPTH - 1));
    endtask

    task automatic quiet();
        cmd_load = 1'b0;
        cmd_run  = 1'b0;
        rd_req   = 1'b0;
    endtask

    task automatic check_image(input string name);
        int errs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== model_mem[i]) errs++;
        chk(name, 32'(errs), 32'd0);
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        quiet();
        ld_valid = 1'b0; ld_last = 1'b0; cpu_ready = 1'b0; cpu_we = 1'b0; cpu_idle = 1'b1;
        e_busy = 0; e_done = 0; e_ld_ready = 0; e_start = 0; e_rst = 1; e_tmo = 0;
        e_rvalid = 0; e_rdata = '0; e_mux = 0; e_we = 4'h0;
        chk_en = 1'b1;
        step();
        step();
        ap_rst_n = 1'b1;
        step();
        step();
        e_rst = 0;
    endtask

    task automatic do_load(input int n, input bit use_last, input bit fixed, input bit all_cmds);
        int addr = 0;
        bit live = 1'b1;
        cmd_load = 1'b1;
        cmd_run  = all_cmds;
        rd_req   = all_cmds;
        e_we = 4'h0;
        step();
        e_busy = 1; e_done = 0; e_tmo = 0; e_ld_ready = 1;
        while (live) begin
            noise();
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = fixed ? prog[addr] : $urandom;
            ld_last  = use_last && (addr == n - 1);
            e_we     = ld_valid ? 4'hF : 4'h0;
            e_addr   = 10'(addr);
            step();
            if (ld_valid) begin
                model_mem[addr] = ld_data;
                if (ld_last || addr == DEPTH - 1) live = 1'b0;
                addr++;
            end
        end
        quiet();
        ld_valid = 1'b0; ld_last = 1'b0;
        e_we = 4'h0; e_busy = 0; e_ld_ready = 0;
    endtask

    task automatic do_run(input int idle_after, input bit never_idle, input int budget, input bit pinned);
        int r = 0;
        bit live = 1'b1;
        cmd_run = 1'b1; cpu_idle = 1'b1;
        step();
        cmd_run = 1'b0;
        e_busy = 1; e_done = 0; e_tmo = 0; e_start = 1;
        for (int k = 0; k < 4; k++) begin
            noise();
            cpu_ready = (k == 3);
            step();
        end
        quiet();
        cpu_ready = 1'b0; e_start = 0; e_mux = 1;
        while (live) begin
            noise();
            cpu_idle = (r == 0) || (!never_idle && r >= idle_after);
            if (pinned && r == 5) begin
                cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_d = 32'hDEADBEEF; cpu_strb = 4'hF;
            end else if (pinned && r == 6) begin
                cpu_we = 1'b1; cpu_addr = 10'h3FE; cpu_d = 32'hAABBCCDD; cpu_strb = 4'b0010;
            end else begin
                cpu_we   = ($urandom_range(0, 1) == 1);
                cpu_addr = 10'($urandom_range(0, 10'h2FF));
                cpu_d    = $urandom;
                cpu_strb = 4'($urandom_range(0, 15));
            end
            step();
            if (cpu_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (cpu_strb[b]) model_mem[cpu_addr][8*b +: 8] = cpu_d[8*b +: 8];
                end
            end
            if (r > 0 && cpu_idle) begin
                quiet(); cpu_we = 1'b0;
                e_mux = 0; e_busy = 0; e_done = 1;
                live = 1'b0;
            end
`ifdef RUN_WDOG_EN
            else if (r == WDOG - 1) begin
                quiet(); cpu_we = 1'b0;
                e_mux = 0; e_rst = 1;
                step();
                step();
                e_rst = 0; e_busy = 0; e_done = 1; e_tmo = 1;
                live = 1'b0;
            end
`endif
            else if (r + 1 == budget) begin
                quiet(); cpu_we = 1'b0;
                live = 1'b0;
            end
            r++;
        end
        cpu_idle = never_idle ? 1'b0 : 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit from_done = e_done;
        rd_req = 1'b1; rd_addr = a;
        step();
        rd_req = 1'b0; rd_addr = ~a;
        e_busy = 1; e_done = 0;
        noise();
        step();
        noise();
        step();
        quiet();
        e_busy = 0; e_done = from_done; e_rvalid = 1; e_rdata = model_mem[a];
        step();
        e_rvalid = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        prog[0] = 32'h00000013; prog[1] = 32'h00100093; prog[2] = 32'h00208113; prog[3] = 32'h0000006F;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        quiet();
        ap_rst_n = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0; rd_addr = '0;
        cpu_ready = 1'b0; cpu_idle = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_d = '0; cpu_strb = '0;
        step();
        do_reset();

        do_load(4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) chk("prog_word", mem[i], prog[i]);
        check_image("image_after_prog");

        do_run(50, 1'b0, 1000, 1'b1);
        chk("core_word_3ff", mem[10'h3FF], 32'hDEADBEEF);
        chk("strb_byte1_only", mem[10'h3FE], 32'h0000CC00);
        check_image("image_after_run");

        do_read(10'h3FF);
        chk("rd_deadbeef", rd_data, 32'hDEADBEEF);
        do_read(10'h3FE);
        chk("rd_strb_word", rd_data, 32'h0000CC00);
        for (int i = 0; i < 3; i++) do_read(10'($urandom_range(0, DEPTH - 1)));

        do_load(1025, 1'b0, 1'b0, 1'b1);
        ld_valid = 1'b1; ld_data = $urandom; e_we = 4'h0;
        step();
        ld_valid = 1'b0;
        check_image("image_after_full_load");

        do_load(6, 1'b1, 1'b0, 1'b1);
        do_run(20 + $urandom_range(0, 30), 1'b0, 1000, 1'b0);
        check_image("image_after_run2");
        for (int i = 0; i < 4; i++) do_read(10'($urandom_range(0, DEPTH - 1)));

`ifdef RUN_WDOG_EN
        do_run(0, 1'b1, 1000, 1'b0);
        chk("timeout_after_abort", 32'(timeout), 32'd1);
        do_read(10'($urandom_range(0, DEPTH - 1)));
        do_run(30, 1'b0, 1000, 1'b0);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        check_image("image_after_wdog");
`endif

        do_run(0, 1'b1, 60, 1'b0);
        do_reset();
        check_image("image_after_reset");
        do_read(10'($urandom_range(0, DEPTH - 1)));
        do_load(3, 1'b1, 1'b0, 1'b0);
        do_read(10'd1);
        check_image("image_final");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
